// File: rtl/disp_scan_ctrl.sv
// Raster counter and one-line-ahead DDR fetch scheduler with ping-pong line buffer tracking.
// Optional macro DISP_UNDERRUN_CNT_EN enables the saturating underrun event counter.

package pkg_disp;
    typedef struct packed {
        logic [10:0] horz_pix;
        logic [10:0] horz_front_porch;
        logic [10:0] horz_sync;
        logic [10:0] horz_back_porch;
        logic [10:0] vert_pix;
        logic [10:0] vert_front_porch;
        logic [10:0] vert_sync;
        logic [10:0] vert_back_porch;
    } t_sync;
endpackage

module disp_scan_ctrl
    import pkg_disp::*;
#(
    parameter int                ADDR_W      = 29,
    parameter logic [ADDR_W-1:0] LINE_STRIDE = 29'h400
) (
    input  logic              clk,
    input  logic              rst,
    input  t_sync             sp,
    output logic [10:0]       x,
    output logic [10:0]       y,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [10:0]       rd_len,
    input  logic              rd_ack,
    input  logic              rd_done,
    output logic              buf_wr_sel,
    output logic              buf_rd_sel,
    input  logic [ADDR_W-1:0] fb_base_next,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              underrun,
    input  logic              underrun_clr,
    output logic [15:0]       underrun_cnt
);

    typedef enum logic {
        S_IDLE,
        S_REQ
    } t_state;

    t_state            state;
    t_state            state_next;
    logic [11:0]       h_total;
    logic [11:0]       v_total;
    logic              x_wrap;
    logic              y_last;
    logic [10:0]       nl;
    logic              first;
    logic              line_trig;
    logic              trigger;
    logic              line0;
    logic              do_swap;
    logic [ADDR_W-1:0] base_cur;
    logic [ADDR_W-1:0] acc;
    logic [ADDR_W-1:0] acc_next;
    logic              load_req;
    logic              drop;
    logic              late;
    logic              consume;
    logic [1:0]        ready;
    logic [1:0]        ready_next;

    // Timing totals are static while running, so they are simply re-registered every cycle.
    always_ff @(posedge clk) begin
        h_total <= {1'b0, sp.horz_pix} + {1'b0, sp.horz_front_porch}
                 + {1'b0, sp.horz_sync} + {1'b0, sp.horz_back_porch};
        v_total <= {1'b0, sp.vert_pix} + {1'b0, sp.vert_front_porch}
                 + {1'b0, sp.vert_sync} + {1'b0, sp.vert_back_porch};
    end

    assign x_wrap = ({1'b0, x} == h_total - 12'd1);
    assign y_last = ({1'b0, y} == v_total - 12'd1);
    assign nl     = y_last ? 11'd0 : y + 11'd1;

    // buf_rd_sel is loaded from the next line number so it always equals y[0].
    always_ff @(posedge clk) begin
        if (rst) begin
            x          <= '0;
            y          <= '0;
            buf_rd_sel <= 1'b0;
            first      <= 1'b1;
        end else begin
            first <= 1'b0;
            if (x_wrap) begin
                x          <= '0;
                y          <= nl;
                buf_rd_sel <= nl[0];
            end else begin
                x <= x + 11'd1;
            end
        end
    end

    assign line_trig = (x == sp.horz_pix) && (nl < sp.vert_pix);
    assign trigger   = first || line_trig;
    assign line0     = first || (line_trig && (nl == 11'd0));
    assign do_swap   = line0 && swap_req;
    assign acc_next  = line0 ? (do_swap ? fb_base_next : base_cur) : acc + LINE_STRIDE;

    // The accumulator advances on every trigger, even a dropped one, to stay aligned with lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_cur <= '0;
            acc      <= '0;
            swap_ack <= 1'b0;
        end else begin
            swap_ack <= do_swap;
            if (do_swap) begin
                base_cur <= fb_base_next;
            end
            if (trigger) begin
                acc <= acc_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_req   = 1'b0;
        drop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (trigger) begin
                    state_next = S_REQ;
                    load_req   = 1'b1;
                end
            end
            S_REQ: begin
                drop = trigger;
                if (rd_ack) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign rd_req = (state == S_REQ);
    assign rd_len = sp.horz_pix;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr <= '0;
        end else if (load_req) begin
            rd_addr <= acc_next;
        end
    end

    assign consume = (x == sp.horz_pix) && (y < sp.vert_pix);

    // A completing write beats a same-cycle consume of the same entry.
    always_comb begin
        ready_next = ready;
        if (consume) begin
            ready_next[buf_rd_sel] = 1'b0;
        end
        if (rd_done) begin
            ready_next[buf_wr_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready      <= 2'b00;
            buf_wr_sel <= 1'b0;
        end else begin
            ready <= ready_next;
            if (rd_done) begin
                buf_wr_sel <= ~buf_wr_sel;
            end
        end
    end

    // Line 0 of the first frame after reset never had a fetch slot, so it is not checked.
    assign late = !first && (x == 11'd0) && (y < sp.vert_pix) && !ready[buf_rd_sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            underrun <= 1'b0;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end else if (drop || late) begin
            underrun <= 1'b1;
        end
    end

`ifdef DISP_UNDERRUN_CNT_EN
    logic [15:0] cnt_q;
    logic [1:0]  cnt_inc;
    logic [16:0] cnt_sum;

    assign cnt_inc = {1'b0, drop} + {1'b0, late};
    assign cnt_sum = {1'b0, cnt_q} + {15'd0, cnt_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (underrun_clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end

    assign underrun_cnt = cnt_q;
`else
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl: 16x8 raster, auto-acking DDR model with 4-cycle completion.

module tb_disp_scan_ctrl;
    import pkg_disp::*;

    localparam int ADDR_W = 29;
`ifdef DISP_UNDERRUN_CNT_EN
    localparam int CNT_ON = 1;
`else
    localparam int CNT_ON = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    t_sync             sp;
    logic [10:0]       x;
    logic [10:0]       y;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [10:0]       rd_len;
    logic              rd_ack;
    logic              rd_done;
    logic              buf_wr_sel;
    logic              buf_rd_sel;
    logic [ADDR_W-1:0] fb_base_next;
    logic              swap_req;
    logic              swap_ack;
    logic              underrun;
    logic              underrun_clr;
    logic [15:0]       underrun_cnt;

    int checks = 0;
    int errors = 0;
    bit auto_ack;
    bit skip_done;
    int done_cd;

    always #5 clk = ~clk;

    disp_scan_ctrl #(.ADDR_W(ADDR_W), .LINE_STRIDE(29'h400)) dut (
        .clk(clk), .rst(rst), .sp(sp), .x(x), .y(y),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
        .rd_ack(rd_ack), .rd_done(rd_done),
        .buf_wr_sel(buf_wr_sel), .buf_rd_sel(buf_rd_sel),
        .fb_base_next(fb_base_next), .swap_req(swap_req), .swap_ack(swap_ack),
        .underrun(underrun), .underrun_clr(underrun_clr), .underrun_cnt(underrun_cnt)
    );

    // Advance n cycles; the DDR model acks any pending request and completes it 4 cycles later.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            rd_done = 1'b0;
            if (done_cd > 0) begin
                done_cd--;
                if (done_cd == 0) begin
                    if (skip_done) skip_done = 1'b0;
                    else rd_done = 1'b1;
                end
            end
            rd_ack = auto_ack && rd_req;
            if (rd_ack) done_cd = 4;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_x"}, 32'(x), 32'd0);
        checkOutput({tag, "_y"}, 32'(y), 32'd0);
        checkOutput({tag, "_rd_req"}, 32'(rd_req), 32'd0);
        checkOutput({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        checkOutput({tag, "_swap_ack"}, 32'(swap_ack), 32'd0);
        checkOutput({tag, "_underrun"}, 32'(underrun), 32'd0);
        checkOutput({tag, "_cnt"}, 32'(underrun_cnt), 32'd0);
        checkOutput({tag, "_wr_sel"}, 32'(buf_wr_sel), 32'd0);
        checkOutput({tag, "_rd_sel"}, 32'(buf_rd_sel), 32'd0);
    endtask

    initial begin
        rst                 = 1'b1;
        sp.horz_pix         = 11'd8;
        sp.horz_front_porch = 11'd2;
        sp.horz_sync        = 11'd2;
        sp.horz_back_porch  = 11'd4;
        sp.vert_pix         = 11'd4;
        sp.vert_front_porch = 11'd1;
        sp.vert_sync        = 11'd1;
        sp.vert_back_porch  = 11'd2;
        rd_ack              = 1'b0;
        rd_done             = 1'b0;
        fb_base_next        = 29'h1000;
        swap_req            = 1'b1;
        underrun_clr        = 1'b0;
        auto_ack            = 1'b1;
        skip_done           = 1'b0;
        done_cd             = 0;

        applyStimulus(3);
        checkResetState("reset");
        rst = 1'b0;

        // Reset release with swap: line-0 fetch from the new base
        applyStimulus(1);
        checkOutput("first_req", 32'(rd_req), 32'd1);
        checkOutput("first_addr", 32'(rd_addr), 32'h1000);
        checkOutput("first_swap_ack", 32'(swap_ack), 32'd1);
        checkOutput("first_x", 32'(x), 32'd1);
        checkOutput("rd_len", 32'(rd_len), 32'd8);
        swap_req = 1'b0;
        applyStimulus(1);
        checkOutput("swap_ack_pulse", 32'(swap_ack), 32'd0);
        checkOutput("req_zero_wait_fall", 32'(rd_req), 32'd0);
        applyStimulus(4);
        checkOutput("wr_sel_toggle1", 32'(buf_wr_sel), 32'd1);
        applyStimulus(3);
        checkOutput("line1_req", 32'(rd_req), 32'd1);
        checkOutput("line1_addr", 32'(rd_addr), 32'h1400);
        applyStimulus(6);
        checkOutput("x_max", 32'(x), 32'd15);
        checkOutput("y_before_wrap", 32'(y), 32'd0);
        applyStimulus(1);
        checkOutput("x_wrap", 32'(x), 32'd0);
        checkOutput("y_step", 32'(y), 32'd1);
        checkOutput("rd_sel_line1", 32'(buf_rd_sel), 32'd1);
        checkOutput("wr_sel_toggle2", 32'(buf_wr_sel), 32'd0);
        applyStimulus(9);
        checkOutput("line2_addr", 32'(rd_addr), 32'h1800);
        checkOutput("line2_req", 32'(rd_req), 32'd1);
        applyStimulus(16);
        checkOutput("line3_addr", 32'(rd_addr), 32'h1C00);
        applyStimulus(16);
        checkOutput("y3", 32'(y), 32'd3);
        checkOutput("no_req_y3", 32'(rd_req), 32'd0);
        applyStimulus(64);
        checkOutput("y7", 32'(y), 32'd7);
        checkOutput("line0_req", 32'(rd_req), 32'd1);
        checkOutput("line0_addr", 32'(rd_addr), 32'h1000);
        checkOutput("line0_no_swap", 32'(swap_ack), 32'd0);
        applyStimulus(6);
        checkOutput("y7_x15", 32'(x), 32'd15);
        applyStimulus(1);
        checkOutput("frame_wrap_y", 32'(y), 32'd0);
        checkOutput("frame_wrap_x", 32'(x), 32'd0);
        applyStimulus(2);
        checkOutput("no_underrun_frame1", 32'(underrun), 32'd0);

        // Mid-frame swap request only lands at the line-0 trigger
        fb_base_next = 29'h8000;
        swap_req     = 1'b1;
        applyStimulus(7);
        checkOutput("swap_pending_addr", 32'(rd_addr), 32'h1400);
        checkOutput("swap_pending_ack", 32'(swap_ack), 32'd0);
        applyStimulus(112);
        checkOutput("swap_addr", 32'(rd_addr), 32'h8000);
        checkOutput("swap_ack", 32'(swap_ack), 32'd1);
        swap_req = 1'b0;
        applyStimulus(1);
        checkOutput("swap_ack_once", 32'(swap_ack), 32'd0);
        applyStimulus(15);
        checkOutput("post_swap_addr", 32'(rd_addr), 32'h8400);
        checkOutput("post_swap_req", 32'(rd_req), 32'd1);
        checkOutput("no_underrun_frame2", 32'(underrun), 32'd0);

        // Stall the DDR port: late line first, then a dropped request
        applyStimulus(1);
        auto_ack = 1'b0;
        applyStimulus(15);
        checkOutput("stall_req", 32'(rd_req), 32'd1);
        checkOutput("stall_addr", 32'(rd_addr), 32'h8800);
        applyStimulus(7);
        checkOutput("late_detect_lag", 32'(underrun), 32'd0);
        applyStimulus(1);
        checkOutput("late_flag", 32'(underrun), 32'd1);
        checkOutput("late_cnt", 32'(underrun_cnt), 32'(CNT_ON));
        underrun_clr = 1'b1;
        applyStimulus(1);
        checkOutput("clr_flag", 32'(underrun), 32'd0);
        checkOutput("clr_cnt", 32'(underrun_cnt), 32'd0);
        underrun_clr = 1'b0;
        applyStimulus(7);
        checkOutput("drop_req_held", 32'(rd_req), 32'd1);
        checkOutput("drop_addr_held", 32'(rd_addr), 32'h8800);
        checkOutput("drop_flag", 32'(underrun), 32'd1);
        checkOutput("drop_cnt", 32'(underrun_cnt), 32'(CNT_ON));

        // Reset while a request is outstanding
        rst = 1'b1;
        applyStimulus(1);
        checkResetState("mid_req_reset");
        done_cd   = 0;
        skip_done = 1'b0;
        applyStimulus(1);
        fb_base_next = 29'h2000;
        swap_req     = 1'b1;
        auto_ack     = 1'b1;
        rst          = 1'b0;

        // Withhold completion of line 1
        applyStimulus(1);
        checkOutput("rerun_addr", 32'(rd_addr), 32'h2000);
        checkOutput("rerun_swap_ack", 32'(swap_ack), 32'd1);
        swap_req = 1'b0;
        applyStimulus(6);
        checkOutput("rerun_wr_sel", 32'(buf_wr_sel), 32'd1);
        skip_done = 1'b1;
        applyStimulus(9);
        checkOutput("withhold_y", 32'(y), 32'd1);
        checkOutput("withhold_pre", 32'(underrun), 32'd0);
        applyStimulus(1);
        checkOutput("withhold_flag", 32'(underrun), 32'd1);
        checkOutput("withhold_cnt", 32'(underrun_cnt), 32'(CNT_ON));
        checkOutput("withhold_wr_sel", 32'(buf_wr_sel), 32'd1);
        underrun_clr = 1'b1;
        applyStimulus(1);
        checkOutput("withhold_clr_flag", 32'(underrun), 32'd0);
        checkOutput("withhold_clr_cnt", 32'(underrun_cnt), 32'd0);
        underrun_clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
